// File: rtl/load_value_table.sv
// ----------------------------------------------------------------------------
// load_value_table
//
// PC-indexed last-value load predictor. A load in EX looks the table up and
// receives a registered prediction one cycle later; a load completing in MEM
// trains the entry with the value the d_cache really returned.
//
// Only entries whose confidence has reached CONF_THRESH report pred_hit. On a
// miss the prediction value is driven to zero, which is the fallback value of
// the consuming value_prediction stage.
//
// Optional feature, selected at build time:
//   LVT_STRIDE_PRED_EN  - each entry also keeps a stride; prediction becomes
//                         last + stride (stride predictor). Undefined gives a
//                         pure last-value predictor with no stride storage.
//
// Address decode (ADDR_WIDTH must exceed INDEX_WIDTH + TAG_WIDTH + 2):
//   index = pc[INDEX_WIDTH+1:2]
//   tag   = pc[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2]
// ----------------------------------------------------------------------------
module load_value_table #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_WIDTH = 6,
   parameter int TAG_WIDTH   = 8,
   parameter int CONF_BITS   = 2,
   parameter int CONF_THRESH = 2   // 0 < CONF_THRESH <= 2**CONF_BITS-1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // lookup port (EX)
   input  logic                  lookup_en,
   input  logic [ADDR_WIDTH-1:0] lookup_pc,
   output logic                  pred_valid,
   output logic                  pred_hit,
   output logic [DATA_WIDTH-1:0] pred_value,
   // training port (MEM)
   input  logic                  upd_en,
   input  logic [ADDR_WIDTH-1:0] upd_pc,
   input  logic [DATA_WIDTH-1:0] upd_data,
   // whole-table invalidate
   input  logic                  flush
);

   // -------------------------------------------------------------------------
   // Geometry and constants
   // -------------------------------------------------------------------------
   localparam int ENTRIES = 1 << INDEX_WIDTH;
   localparam int IDX_LSB = 2;
   localparam int TAG_LSB = INDEX_WIDTH + 2;
   localparam int TAG_MSB = INDEX_WIDTH + TAG_WIDTH + 1;

   localparam logic [CONF_BITS-1:0] CONF_MAX = '1;
   localparam logic [CONF_BITS-1:0] CONF_THR = CONF_BITS'(CONF_THRESH);
   localparam logic [CONF_BITS-1:0] CONF_ONE = CONF_BITS'(1);

   typedef logic [INDEX_WIDTH-1:0] idx_t;
   typedef logic [TAG_WIDTH-1:0]   tag_t;
   typedef logic [DATA_WIDTH-1:0]  data_t;
   typedef logic [CONF_BITS-1:0]   conf_t;

   // -------------------------------------------------------------------------
   // Table storage
   //   valid/conf carry architectural meaning right after reset and are reset.
   //   tag/last/stride are only ever consulted behind a valid bit.
   // -------------------------------------------------------------------------
   logic [ENTRIES-1:0] valid_q;
   conf_t              conf_q [ENTRIES];
   tag_t               tag_q  [ENTRIES];
   data_t              last_q [ENTRIES];
`ifdef LVT_STRIDE_PRED_EN
   data_t              stride_q [ENTRIES];
`endif

   // -------------------------------------------------------------------------
   // Address decode for both ports
   // -------------------------------------------------------------------------
   idx_t lkp_idx;
   tag_t lkp_tag;
   idx_t upd_idx;
   tag_t upd_tag;

   assign lkp_idx = lookup_pc[TAG_LSB-1:IDX_LSB];
   assign lkp_tag = lookup_pc[TAG_MSB:TAG_LSB];
   assign upd_idx = upd_pc[TAG_LSB-1:IDX_LSB];
   assign upd_tag = upd_pc[TAG_MSB:TAG_LSB];

   // PC bits outside index/tag never influence the table.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{lookup_pc[ADDR_WIDTH-1:TAG_MSB+1], lookup_pc[IDX_LSB-1:0],
                             upd_pc[ADDR_WIDTH-1:TAG_MSB+1],    upd_pc[IDX_LSB-1:0]};

   // -------------------------------------------------------------------------
   // Lookup path: read the current (pre-update, pre-flush) table contents.
   // Because all table writes land on the clock edge, a same-cycle update or
   // flush cannot disturb this read; read-before-write falls out naturally.
   // -------------------------------------------------------------------------
   data_t lkp_pred;
   logic  lkp_tag_match;
   logic  lkp_confident;
   logic  lkp_hit;

`ifdef LVT_STRIDE_PRED_EN
   assign lkp_pred = last_q[lkp_idx] + stride_q[lkp_idx];
`else
   assign lkp_pred = last_q[lkp_idx];
`endif

   assign lkp_tag_match = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
   assign lkp_confident = (conf_q[lkp_idx] >= CONF_THR);
   assign lkp_hit       = lkp_tag_match && lkp_confident;

   // -------------------------------------------------------------------------
   // Response registers
   // -------------------------------------------------------------------------
   logic  pred_valid_q, pred_valid_d;
   logic  pred_hit_q,   pred_hit_d;
   data_t pred_value_q, pred_value_d;

   // Next response: hit/value are forced to zero unless a confident hit is being answered.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      pred_valid_d = lookup_en;
      pred_hit_d   = 1'b0;
      pred_value_d = '0;
      if (lookup_en && lkp_hit) begin
         pred_hit_d   = 1'b1;
         pred_value_d = lkp_pred;
      end
   end

   // Response register: one-cycle lookup latency; reset drops any response in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         pred_valid_q <= 1'b0;
         pred_hit_q   <= 1'b0;
         pred_value_q <= '0;
      end else begin
         pred_valid_q <= pred_valid_d;
         pred_hit_q   <= pred_hit_d;
         pred_value_q <= pred_value_d;
      end
   end

   assign pred_valid = pred_valid_q;
   assign pred_hit   = pred_hit_q;
   assign pred_value = pred_value_q;

   // -------------------------------------------------------------------------
   // Training path
   //   hit   (valid && tag match): conf++ (saturating) when the old prediction
   //                                was right, conf=0 otherwise; last=upd_data.
   //   miss                      : allocate with conf=0, last=upd_data.
   // For a last-value predictor a correct prediction means last==upd_data,
   // so writing last=upd_data unconditionally is equivalent and keeps the
   // stride variant (where last must advance every update) on the same path.
   // -------------------------------------------------------------------------
   data_t upd_pred;
   logic  upd_match;
   logic  upd_correct;
   logic  upd_we;
   conf_t conf_d;
   data_t last_d;
`ifdef LVT_STRIDE_PRED_EN
   data_t stride_d;
`endif

`ifdef LVT_STRIDE_PRED_EN
   assign upd_pred = last_q[upd_idx] + stride_q[upd_idx];
`else
   assign upd_pred = last_q[upd_idx];
`endif

   assign upd_match   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   assign upd_correct = (upd_data == upd_pred);

   // Flush wins over a same-cycle update; that update is discarded entirely.
   assign upd_we = upd_en && !flush;

   // New entry contents for the index being trained.
   always_comb begin
      conf_d = '0;
      last_d = upd_data;
`ifdef LVT_STRIDE_PRED_EN
      stride_d = '0;
`endif
      if (upd_match) begin
         if (upd_correct) begin
            conf_d = (conf_q[upd_idx] == CONF_MAX) ? CONF_MAX
                                                  : conf_q[upd_idx] + CONF_ONE;
         end
`ifdef LVT_STRIDE_PRED_EN
         // Modulo-2**DATA_WIDTH difference against the old last value.
         stride_d = upd_data - last_q[upd_idx];
`endif
      end
   end

   // Valid bits: flush clears all in one cycle, otherwise an update marks its entry valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (flush) begin
         valid_q <= '0;
      end else if (upd_en) begin
         valid_q[upd_idx] <= 1'b1;
      end
   end

   // Confidence counters: cleared on reset, written by each accepted update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            conf_q[i] <= '0;
         end
      end else if (upd_we) begin
         conf_q[upd_idx] <= conf_d;
      end
   end

   // Tag and data payload: written by each accepted update.
   always_ff @(posedge clk) begin
      // NOTE: payload arrays carry no reset; they are only read behind valid, so a reset here would add fanout for nothing.
      if (upd_we) begin
         tag_q[upd_idx]  <= upd_tag;
         last_q[upd_idx] <= last_d;
`ifdef LVT_STRIDE_PRED_EN
         stride_q[upd_idx] <= stride_d;
`endif
      end
   end

endmodule

// File: tb/tb_load_value_table.sv
// ----------------------------------------------------------------------------
// tb_load_value_table
//
// Directed bench for load_value_table with hand-computed expectations.
// Build with +define+LVT_STRIDE_PRED_EN to exercise the stride variant; the
// shared sequences use repeated identical data, which behaves identically in
// both variants (stride stays zero).
// ----------------------------------------------------------------------------
module tb_load_value_table;

   localparam int AW = 32;
   localparam int DW = 32;

   // PCs: A and B alias on index 4 (tags 0x00 / 0x01); C, D, E use other indices.
   localparam logic [AW-1:0] PC_A = 32'h0040_0010;
   localparam logic [AW-1:0] PC_B = 32'h0040_0110;
   localparam logic [AW-1:0] PC_C = 32'h0040_0020;
`ifdef LVT_STRIDE_PRED_EN
   localparam logic [AW-1:0] PC_D = 32'h0040_0030;
   localparam logic [AW-1:0] PC_E = 32'h0040_0040;
`endif

   logic          clk;
   logic          rst_n;
   logic          lookup_en;
   logic [AW-1:0] lookup_pc;
   logic          pred_valid;
   logic          pred_hit;
   logic [DW-1:0] pred_value;
   logic          upd_en;
   logic [AW-1:0] upd_pc;
   logic [DW-1:0] upd_data;
   logic          flush;

   int n_cmp = 0;
   int n_err = 0;

   load_value_table #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .INDEX_WIDTH (6),
      .TAG_WIDTH   (8),
      .CONF_BITS   (2),
      .CONF_THRESH (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lookup_en  (lookup_en),
      .lookup_pc  (lookup_pc),
      .pred_valid (pred_valid),
      .pred_hit   (pred_hit),
      .pred_value (pred_value),
      .upd_en     (upd_en),
      .upd_pc     (upd_pc),
      .upd_data   (upd_data),
      .flush      (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [AW-1:0] pc, input logic [DW-1:0] data);
      upd_en   = 1'b1;
      upd_pc   = pc;
      upd_data = data;
      tick();
      upd_en   = 1'b0;
   endtask

   task automatic lookup_chk(input string tag, input logic [AW-1:0] pc,
                             input logic exp_hit, input logic [DW-1:0] exp_val);
      lookup_en = 1'b1;
      lookup_pc = pc;
      tick();
      lookup_en = 1'b0;
      check({tag, ".valid"}, DW'(pred_valid), DW'(1));
      check({tag, ".hit"},   DW'(pred_hit),   DW'(exp_hit));
      check({tag, ".value"}, pred_value,      exp_val);
   endtask

   initial begin
      rst_n     = 1'b0;
      lookup_en = 1'b0;
      lookup_pc = '0;
      upd_en    = 1'b0;
      upd_pc    = '0;
      upd_data  = '0;
      flush     = 1'b0;

      // Reset state
      repeat (2) tick();
      check("rst.valid", DW'(pred_valid), DW'(0));
      check("rst.hit",   DW'(pred_hit),   DW'(0));
      check("rst.value", pred_value,      DW'(0));
      rst_n = 1'b1;
      tick();

      // Cold lookup misses; response lasts exactly one cycle
      lookup_chk("cold", PC_A, 1'b0, '0);
      tick();
      check("idle.valid", DW'(pred_valid), DW'(0));
      check("idle.hit",   DW'(pred_hit),   DW'(0));

      // Training: allocate (conf 0) -> 1 -> 2 reaches threshold
      upd(PC_A, 32'h1234);
      lookup_chk("conf0", PC_A, 1'b0, '0);
      upd(PC_A, 32'h1234);
      lookup_chk("conf1", PC_A, 1'b0, '0);
      upd(PC_A, 32'h1234);
      lookup_chk("conf2", PC_A, 1'b1, 32'h1234);

`ifndef LVT_STRIDE_PRED_EN
      // Saturation at 3, then a misprediction resets confidence
      upd(PC_A, 32'h1234);            // conf 3
      upd(PC_A, 32'h1234);            // stays 3
      lookup_chk("sat", PC_A, 1'b1, 32'h1234);
      upd(PC_A, 32'h5678);            // conf 0, last 0x5678
      lookup_chk("mispred", PC_A, 1'b0, '0);
      upd(PC_A, 32'h5678);            // conf 1
      lookup_chk("retrain1", PC_A, 1'b0, '0);
      upd(PC_A, 32'h5678);            // conf 2
      lookup_chk("retrain2", PC_A, 1'b1, 32'h5678);
`else
      // Stride: 100,104,108,112 -> stride 4, conf 2 -> predict 116
      upd(PC_D, 32'd100);
      upd(PC_D, 32'd104);
      upd(PC_D, 32'd108);
      upd(PC_D, 32'd112);
      lookup_chk("stride", PC_D, 1'b1, 32'd116);
      // Wraparound: last 0xFFFF_FFFC + stride 4 -> 0
      upd(PC_E, 32'hFFFF_FFF0);
      upd(PC_E, 32'hFFFF_FFF4);
      upd(PC_E, 32'hFFFF_FFF8);
      upd(PC_E, 32'hFFFF_FFFC);
      lookup_chk("wrap", PC_E, 1'b1, 32'h0000_0000);
`endif

      // Aliasing: B evicts A at the shared index
      upd(PC_B, 32'hAAAA);
      lookup_chk("evicted", PC_A, 1'b0, '0);
      lookup_chk("alloc",   PC_B, 1'b0, '0);

      // Independent entry at another index
      upd(PC_C, 32'hC0DE);
      upd(PC_C, 32'hC0DE);
      upd(PC_C, 32'hC0DE);
      lookup_chk("other_idx", PC_C, 1'b1, 32'hC0DE);

      // Same-cycle lookup + update, same index: pre-update value returned
      upd(PC_B, 32'hAAAA);            // conf 1
      upd(PC_B, 32'hAAAA);            // conf 2
      lookup_en = 1'b1;
      lookup_pc = PC_B;
      upd_en    = 1'b1;
      upd_pc    = PC_B;
      upd_data  = 32'hBBBB;
      tick();
      lookup_en = 1'b0;
      upd_en    = 1'b0;
      check("rbw.hit",   DW'(pred_hit), DW'(1));
      check("rbw.value", pred_value,    32'hAAAA);
      lookup_chk("rbw_after", PC_B, 1'b0, '0);

      // Same-cycle lookup + update, different index: both proceed
      lookup_en = 1'b1;
      lookup_pc = PC_C;
      upd_en    = 1'b1;
      upd_pc    = PC_B;
      upd_data  = 32'hBBBB;
      tick();
      lookup_en = 1'b0;
      upd_en    = 1'b0;
      check("diff.hit",   DW'(pred_hit), DW'(1));
      check("diff.value", pred_value,    32'hC0DE);

      // Flush + update + lookup in one cycle: lookup sees pre-flush table, update dropped
      flush     = 1'b1;
      lookup_en = 1'b1;
      lookup_pc = PC_C;
      upd_en    = 1'b1;
      upd_pc    = PC_A;
      upd_data  = 32'h1;
      tick();
      flush     = 1'b0;
      lookup_en = 1'b0;
      upd_en    = 1'b0;
      check("flush_cyc.hit",   DW'(pred_hit), DW'(1));
      check("flush_cyc.value", pred_value,    32'hC0DE);
      lookup_chk("flushed_c", PC_C, 1'b0, '0);
      lookup_chk("flushed_a", PC_A, 1'b0, '0);
      // Had the flush-cycle update landed, two more would reach conf 2
      upd(PC_A, 32'h1);               // allocate, conf 0
      upd(PC_A, 32'h1);               // conf 1
      lookup_chk("flush_drop", PC_A, 1'b0, '0);
      upd(PC_A, 32'h1);               // conf 2
      lookup_chk("post_flush", PC_A, 1'b1, 32'h1);

      // Reset asserted while a lookup is in flight drops its response
      lookup_en = 1'b1;
      lookup_pc = PC_A;
      #2;
      rst_n = 1'b0;
      tick();
      lookup_en = 1'b0;
      check("rst_mid.valid", DW'(pred_valid), DW'(0));
      check("rst_mid.hit",   DW'(pred_hit),   DW'(0));
      rst_n = 1'b1;
      tick();
      lookup_chk("post_rst", PC_A, 1'b0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
